// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: per-frame peak bin, peak |X|^2 and half-spectrum energy
// for a bin-ordered FFT stream, published once per frame after a short flush.
module fft_peak_tracker #(
  parameter  int DATA_WIDTH = 24,
  parameter  int FFT_SIZE   = 256,
  parameter  int BIN_W      = 8,
  parameter  int SKIP_DC    = 1,
  localparam int MAG_W      = 2*DATA_WIDTH+1,
  localparam int EN_W       = MAG_W+BIN_W-1
)(
  input  logic                         clk,
  input  logic                         resetb,
  input  logic signed [DATA_WIDTH-1:0] data_real_i,
  input  logic signed [DATA_WIDTH-1:0] data_imag_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         clear_i,
  input  logic [MAG_W-1:0]             threshold_i,
  output logic [BIN_W-1:0]             peak_bin_o,
  output logic [MAG_W-1:0]             peak_mag_o,
  output logic [EN_W-1:0]              energy_o,
  output logic                         detected_o,
  output logic [5:0]                   led_o,
  output logic                         result_valid_o,
  output logic [15:0]                  frame_count_o
);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                         state, state_nx;
  logic                           flush_cnt;
  logic                           publish;
  logic                           xfer;
  logic [BIN_W-1:0]               bin_cnt;

  logic                           s1_vld;
  logic signed [DATA_WIDTH-1:0]   s1_re, s1_im;
  logic [BIN_W-1:0]               s1_bin;
  logic                           s1_last;

  logic signed [2*DATA_WIDTH-1:0] sq_re, sq_im;
  logic [MAG_W-1:0]               mag;
  logic                           eval_bin;

  logic [MAG_W-1:0]               cand_mag;
  logic [BIN_W-1:0]               cand_bin;
  logic [EN_W-1:0]                energy_acc;
  logic                           frame_done;
  logic                           det_now;

  assign xfer = valid_i && ready_o && !clear_i;

  // Squares are non-negative, so the signed products zero-extend into MAG_W.
  assign sq_re    = s1_re * s1_re;
  assign sq_im    = s1_im * s1_im;
  assign mag      = {1'b0, sq_re} + {1'b0, sq_im};
  assign eval_bin = (s1_bin < BIN_W'(FFT_SIZE/2)) && !((SKIP_DC != 0) && (s1_bin == '0));
  assign det_now  = cand_mag >= threshold_i;

  // State register; flush_cnt counts the two FLUSH cycles.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ACCUM;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= (state == FLUSH && !clear_i) ? ~flush_cnt : 1'b0;
    end
  end

  // Next state, ready and the publish strobe; clear always wins.
  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    ready_o  = 1'b0;
    case (state)
      ACCUM: begin
        ready_o = 1'b1;
        if (valid_i && !clear_i && bin_cnt == BIN_W'(FFT_SIZE-1)) state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt) begin
          state_nx = ACCUM;
          publish  = frame_done;
        end
      end
      default: state_nx = ACCUM;
    endcase
    if (clear_i) begin
      state_nx = ACCUM;
      publish  = 1'b0;
    end
  end

  // Stage 1: capture the accepted bin with its index and last-bin flag.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bin_cnt <= '0;
      s1_vld  <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_bin  <= '0;
      s1_last <= 1'b0;
    end else if (clear_i) begin
      bin_cnt <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        bin_cnt <= bin_cnt + 1'b1;
        s1_re   <= data_real_i;
        s1_im   <= data_imag_i;
        s1_bin  <= bin_cnt;
        s1_last <= (bin_cnt == BIN_W'(FFT_SIZE-1));
      end
    end
  end

  // Stage 2: magnitude into peak candidate and energy; reset on publish/clear.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cand_mag   <= '0;
      cand_bin   <= '0;
      energy_acc <= '0;
      frame_done <= 1'b0;
    end else if (clear_i || publish) begin
      cand_mag   <= '0;
      cand_bin   <= '0;
      energy_acc <= '0;
      frame_done <= 1'b0;
    end else if (s1_vld) begin
      if (eval_bin) begin
        energy_acc <= energy_acc + EN_W'(mag);
        if (mag > cand_mag) begin
          cand_mag <= mag;
          cand_bin <= s1_bin;
        end
      end
      if (s1_last) frame_done <= 1'b1;
    end
  end

  // Result registers: updated only on the publish edge, held otherwise.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      peak_bin_o     <= '0;
      peak_mag_o     <= '0;
      energy_o       <= '0;
      detected_o     <= 1'b0;
      led_o          <= '0;
      result_valid_o <= 1'b0;
      frame_count_o  <= '0;
    end else begin
      result_valid_o <= publish;
      if (publish) begin
        peak_bin_o    <= cand_bin;
        peak_mag_o    <= cand_mag;
        energy_o      <= energy_acc;
        detected_o    <= det_now;
        led_o         <= det_now ? cand_bin[BIN_W-2 -: 6] : 6'd0;
        frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end

endmodule

// File: doc/fft_peak_tracker.md
# fft_peak_tracker

Streaming consumer that sits directly downstream of the 256-point FFT. It accepts one complex bin per valid/ready handshake, in bin order. For each frame it computes |X|² per bin over the non-mirrored half-spectrum and publishes a result set: peak bin, peak magnitude, half-spectrum energy, a detection flag and a 6-LED bar. This replaces ad-hoc peak logic in the top level with a pipelined, frame-synchronous block that has defined backpressure.

## Interface
- DATA_WIDTH, 24, width of signed real/imag input
- FFT_SIZE, 256, bins per frame (power of two)
- BIN_W, 8, log2(FFT_SIZE)
- SKIP_DC, 1, when 1, bin 0 is excluded from peak search and energy
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- data_real_i  in  DATA_WIDTH  signed real part of current bin
- data_imag_i  in  DATA_WIDTH  signed imaginary part of current bin
- valid_i  in  1  input bin valid
- ready_o  out  1  block accepts a bin
- clear_i  in  1  synchronous frame abort
- threshold_i  in  MAG_W  minimum peak magnitude for detection (MAG_W = 2*DATA_WIDTH+1)
- peak_bin_o  out  BIN_W  bin index of last frame's peak
- peak_mag_o  out  MAG_W  |X|² of that peak
- energy_o  out  MAG_W+BIN_W-1  sum of |X|² over evaluated bins
- detected_o  out  1  peak_mag_o >= threshold_i at publish time
- led_o  out  6  peak_bin_o[BIN_W-2 -: 6] when detected, else 0
- result_valid_o  out  1  one-cycle pulse when outputs update
- frame_count_o  out  16  completed frames, wraps at 65535→0

## Operation
- Handshake: a bin transfers when valid_i && ready_o. bin_cnt increments per transfer and wraps FFT_SIZE-1→0. The first transfer after reset or clear_i is bin 0.
- Pipeline: S1 registers real, imag, bin index and last flag. S2 computes re² + im² (full precision, MAG_W bits, unsigned) and updates the accumulators.
- Evaluated bins: index < FFT_SIZE/2, and index ≥ 1 when SKIP_DC=1. Other bins are consumed and ignored.
- Peak update: strictly-greater compare, so on a tie the earliest bin wins. The candidate register starts at 0 with bin 0. If every evaluated magnitude is 0, peak_bin_o = 0.
- Energy: accumulates with no saturation. Width is sized for the worst case.
- FSM ACCUM/FLUSH:
  - ACCUM: ready_o=1. A transfer of bin FFT_SIZE-1 → FLUSH.
  - FLUSH: ready_o=0 for 2 cycles, then → ACCUM.
  - On the exit edge: latch outputs, compute detected_o and led_o, pulse result_valid_o, increment frame_count_o, clear the candidate and energy accumulators.
- clear_i: → ACCUM, bin_cnt=0, pipeline and accumulators cleared, outputs held, no pulse. A transfer in the same cycle as clear_i is dropped (clear wins). clear_i during FLUSH cancels that publish.
- Reset values: ready_o=1, result_valid_o=0, every other output 0, state ACCUM.
- Reset mid-frame: the partial frame is discarded. No result is published.

## Timing
- Last-bin transfer in cycle L: ready_o=0 in L+1 and L+2. result_valid_o=1 and the new outputs are visible in L+3, with ready_o=1 again in L+3.
- A transfer in L+3 is bin 0 of the next frame and is not lost.
- Outputs hold their values between pulses.
- valid_i gaps stall only bin_cnt. Results do not depend on gap pattern.
- threshold_i is sampled on the publish edge only.

## Test plan
- Tone: bin 10 real=1000, imag=0, all others 0, continuous valid → peak_bin_o=10, peak_mag_o=1_000_000, energy_o=1_000_000, detected_o=1 (threshold 1000), led_o=6'b000101, pulse exactly at L+3.
- Mirror/DC rejection: bin 0 = 30000, bin 246 = 30000, bin 40 = 50+50j → peak_bin_o=40, peak_mag_o=5000, energy_o=5000.
- Tie and threshold: bins 20 and 30 both 100+0j, threshold 10001 → peak_bin_o=20, peak_mag_o=10000, detected_o=0, led_o=0.
- Backpressure/gaps: random valid_i gaps across two frames → identical results to the gap-free run, ready_o low exactly 2 cycles per frame, frame_count_o=2, next-frame bin 0 accepted in L+3.
- Extremes: bin 5 = -2^23 - 2^23j → peak_mag_o=2^47, no overflow.
- Abort: resetb low mid-frame, and separately clear_i at bin 100 simultaneous with a transfer → no pulse, next 256 transfers form a complete frame, outputs reflect only that frame.
